// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: control and timing stage ahead of the UART TX datapath.
// Latches a byte on tx_start, then steps bit_cnto through 0 (start),
// 1..8 (data, LSB first) and 9 (stop), holding each index for
// CLKS_PER_BIT clocks while tx_en is high.
// Optional build macro: UART_TX_B2B_EN. When it is defined, a tx_start on
// the last stop-bit cycle chains the next frame with no idle gap.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for tx_start
// XMIT  | frame on the line, bit_cnto advancing at the baud rate
// DONE  | one-cycle completion slot, tx_done high
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic [9:0] bit_cnto,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                BCNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BCNT_W-1:0] BAUD_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [9:0]        BIT_STOP  = 10'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [BCNT_W-1:0] r_baud_cnt;
    logic [9:0]        r_bit_cnt;
    logic [7:0]        r_tx_data;
    logic              r_tx_en;
    logic              r_tx_done;

    state_t            w_state_nxt;
    logic [BCNT_W-1:0] w_baud_nxt;
    logic [9:0]        w_bit_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_en_nxt;
    logic              w_done_nxt;
    logic              w_baud_last;

    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    // State and registered outputs; synchronous reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_data  <= 8'h00;
            r_tx_en    <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_en    <= w_en_nxt;
            r_tx_done  <= w_done_nxt;
        end
    end

    // Next-state and next register values; everything holds unless changed.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_data_nxt  = r_tx_data;
        w_en_nxt    = r_tx_en;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_en_nxt  = 1'b0;
                w_bit_nxt = '0;
                if (tx_start) begin
                    w_state_nxt = S_XMIT;
                    w_data_nxt  = din;
                    w_bit_nxt   = '0;
                    w_baud_nxt  = '0;
                    w_en_nxt    = 1'b1;
                end
            end

            S_XMIT: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == BIT_STOP) begin
`ifdef UART_TX_B2B_EN
                        if (tx_start) begin
                            // Chain straight into the next start bit.
                            w_data_nxt = din;
                            w_bit_nxt  = '0;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_en_nxt    = 1'b0;
                            w_bit_nxt   = '0;
                            w_done_nxt  = 1'b1;
                        end
`else
                        w_state_nxt = S_DONE;
                        w_en_nxt    = 1'b0;
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 10'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = 1'b0;
                w_bit_nxt   = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = 1'b0;
                w_bit_nxt   = '0;
            end
        endcase
    end

`ifndef SYNTHESIS
    // A divisor below 2 leaves the baud counter with nothing to count.
    always_ff @(posedge clk) begin
        assert (CLKS_PER_BIT >= 2)
            else $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
    end
`endif

    assign tx_data  = r_tx_data;
    assign tx_en    = r_tx_en;
    assign bit_cnto = r_bit_cnt;
    assign tx_done  = r_tx_done;
    assign tx_busy  = (r_state != S_IDLE);

endmodule
